// File: rtl/ws2812_frame_loader.sv
// ws2812_frame_loader: byte-stream front end for the ws2812 serial driver.
// Scales each accepted byte by a global brightness and collects the bytes into
// a shadow frame. A complete frame is copied to packed_rgb_data in one cycle,
// so the driver never samples a partially written frame.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   in_data/in_valid byte stream; in_ready is the combinational accept
//   in_sof           marks in_data as the first byte of a frame
//   brightness       global scale applied per byte, 255 = unity
//   packed_rgb_data  committed frame, LED k at [24k +: 24], bit 23 sent first
//   frame_done       one-cycle pulse when a frame is committed
//   frame_error      one-cycle pulse when a frame is aborted
module ws2812_frame_loader #(
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  input  logic [7:0]              brightness,
  output logic [24*NUM_LEDS-1:0]  packed_rgb_data,
  output logic                    frame_done,
  output logic                    frame_error
);

  localparam int unsigned NB = 3 * NUM_LEDS;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]             state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [24*NUM_LEDS-1:0] shadow;
  logic                   accept;
  logic                   wr_en;
  logic [IW-1:0]          wr_idx;
  logic                   done_nxt, err_nxt;
  logic [16:0]            product;
  logic [7:0]             scaled;

  assign in_ready = !reset && (state != S_COMMIT);
  assign accept   = in_valid && in_ready;

  // (brightness + 1) scaling makes 255 an exact pass-through
  assign product = 17'(in_data) * (17'(brightness) + 17'd1);
  assign scaled  = 8'(product >> 8);

  // Next-state, write-enable and pulse decode
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_idx    = idx;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && in_sof) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          idx_nxt   = IW'(1);
          cnt_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          cnt_nxt = '0;
          if (in_sof) begin
            // Restart: the old partial frame is abandoned and overwritten
            err_nxt = 1'b1;
            wr_idx  = '0;
            idx_nxt = IW'(1);
          end else if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = S_COMMIT;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          // Aborting on the last count keeps the counter from ever wrapping
          if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_COMMIT: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, shadow and committed-frame registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      idx             <= '0;
      cnt             <= '0;
      shadow          <= '0;
      packed_rgb_data <= '0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      frame_done  <= done_nxt;
      frame_error <= err_nxt;
      if (state == S_COMMIT) begin
        packed_rgb_data <= shadow;
      end
      // Byte i belongs to LED i/3; its first byte lands in bits [23:16]
      for (int i = 0; i < int'(NB); i++) begin
        if (wr_en && (wr_idx == IW'(i))) begin
          shadow[8*(3*(i/3) + 2 - (i%3)) +: 8] <= scaled;
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_loader.sv
// Bench for ws2812_frame_loader with NUM_LEDS=2 and TIMEOUT_CYCLES=16.
// A frame-level model tracks the collected bytes and idle time; a compare
// process checks every output against it each cycle, and directed literal
// checks pin the expected frames.
module tb_ws2812_frame_loader;

  localparam int unsigned NL = 2;
  localparam int unsigned NB = 3 * NL;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [7:0]    brightness;
  logic [24*NL-1:0] packed_rgb_data;
  logic          frame_done;
  logic          frame_error;

  int total = 0;
  int bad   = 0;

  ws2812_frame_loader #(.NUM_LEDS(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_sof          (in_sof),
    .in_ready        (in_ready),
    .brightness      (brightness),
    .packed_rgb_data (packed_rgb_data),
    .frame_done      (frame_done),
    .frame_error     (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model
  logic [7:0]       m_frame [NB];
  int               m_n      = 0;
  int               m_idle   = 0;
  bit               m_in     = 0;
  bit               m_commit = 0;
  bit               m_started = 0;
  logic [24*NL-1:0] e_packed = '0;
  logic             e_done   = 0;
  logic             e_err    = 0;

  always @(posedge clk) begin
    m_started = 1;
    if (reset) begin
      m_in = 0; m_n = 0; m_idle = 0; m_commit = 0;
      e_packed = '0; e_done = 0; e_err = 0;
    end else begin
      e_done = 0;
      e_err  = 0;
      if (m_commit) begin
        for (int k = 0; k < int'(NL); k++)
          e_packed[24*k +: 24] = {m_frame[3*k], m_frame[3*k+1], m_frame[3*k+2]};
        e_done   = 1;
        m_commit = 0;
      end else if (in_valid) begin
        logic [7:0] sb;
        sb = 8'((int'(in_data) * (int'(brightness) + 1)) / 256);
        if (in_sof) begin
          if (m_in) e_err = 1;
          m_frame[0] = sb;
          m_n = 1; m_in = 1; m_idle = 0;
        end else if (m_in) begin
          m_frame[m_n] = sb;
          m_n++;
          m_idle = 0;
          if (m_n == int'(NB)) begin
            m_commit = 1;
            m_in = 0;
          end
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle == int'(TO)) begin
          e_err = 1; m_in = 0; m_idle = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("cyc_packed", 64'(packed_rgb_data), 64'(e_packed));
      chk("cyc_done",   64'(frame_done),      64'(e_done));
      chk("cyc_error",  64'(frame_error),     64'(e_err));
      chk("cyc_ready",  64'(in_ready),        64'(!reset && !m_commit));
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic [7:0] b);
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = d; in_sof = s; brightness = b;
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sof = 1'b0; brightness = 8'd255;

    // Reset held for three cycles
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_packed", 64'(packed_rgb_data), 64'h0);
      chk("rst_ready",  64'(in_ready), 64'h0);
      chk("rst_pulses", 64'({frame_done, frame_error}), 64'h0);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1 chk("ready_after_rst", 64'(in_ready), 64'h1);

    // Full frame, unity brightness
    send(8'h11, 1'b1, 8'd255);
    send(8'h22, 1'b0, 8'd255);
    send(8'h33, 1'b0, 8'd255);
    send(8'h44, 1'b0, 8'd255);
    send(8'h55, 1'b0, 8'd255);
    send(8'h66, 1'b0, 8'd255);
    idle();
    chk("commit_ready", 64'(in_ready), 64'h0);
    chk("commit_done_early", 64'(frame_done), 64'h0);
    idle();
    chk("frame_a_done", 64'(frame_done), 64'h1);
    chk("frame_a", 64'(packed_rgb_data), 64'h445566_112233);
    chk("ready_back", 64'(in_ready), 64'h1);
    idle();
    chk("done_one_cycle", 64'(frame_done), 64'h0);

    // Brightness 127 halves each byte
    send(8'hFF, 1'b1, 8'd127);
    send(8'h80, 1'b0, 8'd127);
    send(8'h01, 1'b0, 8'd127);
    send(8'h00, 1'b0, 8'd127);
    send(8'hFF, 1'b0, 8'd127);
    send(8'hFF, 1'b0, 8'd127);
    idle(); idle();
    chk("scale_127", 64'(packed_rgb_data), 64'h007F7F_7F4000);

    // Brightness sampled per byte: only the first byte sees 0
    send(8'hFF, 1'b1, 8'd0);
    send(8'hFF, 1'b0, 8'd255);
    send(8'hFF, 1'b0, 8'd255);
    send(8'hFF, 1'b0, 8'd255);
    send(8'hFF, 1'b0, 8'd255);
    send(8'hFF, 1'b0, 8'd255);
    idle(); idle();
    chk("scale_0", 64'(packed_rgb_data), 64'hFFFFFF_00FFFF);

    // Mid-frame restart
    send(8'hAA, 1'b1, 8'd255);
    send(8'hBB, 1'b0, 8'd255);
    send(8'hCC, 1'b0, 8'd255);
    send(8'h01, 1'b1, 8'd255);
    send(8'h02, 1'b0, 8'd255);
    chk("restart_err", 64'(frame_error), 64'h1);
    send(8'h03, 1'b0, 8'd255);
    chk("restart_err_once", 64'(frame_error), 64'h0);
    send(8'h04, 1'b0, 8'd255);
    send(8'h05, 1'b0, 8'd255);
    send(8'h06, 1'b0, 8'd255);
    idle(); idle();
    chk("restart_done", 64'(frame_done), 64'h1);
    chk("restart_frame", 64'(packed_rgb_data), 64'h040506_010203);

    // Timeout after 16 idle cycles
    send(8'hA1, 1'b1, 8'd255);
    send(8'hA2, 1'b0, 8'd255);
    send(8'hA3, 1'b0, 8'd255);
    send(8'hA4, 1'b0, 8'd255);
    for (int i = 1; i <= 17; i++) begin
      idle();
      if (i < 17) chk("timeout_early", 64'(frame_error), 64'h0);
      else        chk("timeout_err",   64'(frame_error), 64'h1);
    end
    chk("timeout_keep", 64'(packed_rgb_data), 64'h040506_010203);
    send(8'h99, 1'b0, 8'd255);
    send(8'h98, 1'b0, 8'd255);
    idle(); idle(); idle();
    chk("timeout_drop", 64'(packed_rgb_data), 64'h040506_010203);
    chk("timeout_no_done", 64'(frame_done), 64'h0);

    // in_valid held through COMMIT
    send(8'h21, 1'b1, 8'd255);
    send(8'h22, 1'b0, 8'd255);
    send(8'h23, 1'b0, 8'd255);
    send(8'h24, 1'b0, 8'd255);
    send(8'h25, 1'b0, 8'd255);
    send(8'h26, 1'b0, 8'd255);
    send(8'h77, 1'b1, 8'd255);
    chk("bp_ready_low", 64'(in_ready), 64'h0);
    send(8'h10, 1'b1, 8'd255);
    chk("bp_done", 64'(frame_done), 64'h1);
    chk("bp_frame", 64'(packed_rgb_data), 64'h242526_212223);
    send(8'h20, 1'b0, 8'd255);
    chk("bp_no_err", 64'(frame_error), 64'h0);
    send(8'h30, 1'b0, 8'd255);
    send(8'h40, 1'b0, 8'd255);
    send(8'h50, 1'b0, 8'd255);
    send(8'h60, 1'b0, 8'd255);
    idle(); idle();
    chk("bp_next_frame", 64'(packed_rgb_data), 64'h405060_102030);

    // Stray bytes in IDLE are accepted and discarded
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hE0 + i), 1'b0, 8'd255);
      chk("stray_ready", 64'(in_ready), 64'h1);
    end
    idle(); idle(); idle();
    chk("stray_keep", 64'(packed_rgb_data), 64'h405060_102030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
